// File: rtl/io_pkg.sv
// Shared constants for the board input conditioner: default debounce length,
// in_port1 field layout and the debouncer state encoding.
package io_pkg;

  // 1 ms of stable level at the 50 MHz board clock.
  localparam int DB_CYCLES_DEFAULT = 50000;

  // in_port1 layout: debounced key levels at the bottom, sticky flags above.
  localparam int LEVEL_BASE = 0;

  function automatic int flag_base(input int n_key);
    return n_key;
  endfunction

  typedef enum logic {
    STABLE_0 = 1'b0,
    STABLE_1 = 1'b1
  } db_state_e;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Board-pin / CPU-side signal bundle of the input conditioner.
interface io_input_conditioner_if #(
  parameter int N_SW  = 10,
  parameter int N_KEY = 4
);
  // No valid/ready pair here: sw/key_n are free-running asynchronous levels,
  // key_clr is a single-cycle strobe sampled on the next clock edge, and the
  // in_port words are always valid registered snapshots.
  logic [N_SW-1:0]  sw;
  logic [N_KEY-1:0] key_n;
  logic             key_clr;
  logic [31:0]      in_port0;
  logic [31:0]      in_port1;

  modport master (output sw, key_n, key_clr, input in_port0, in_port1);
  modport slave  (input sw, key_n, key_clr, output in_port0, in_port1);
endinterface

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchronizer followed by a counter debouncer.
// The debounced level is the FSM state itself, exported for observation.
module debounce_cell
  import io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 16,
  parameter bit INVERT    = 1'b0
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      raw,
  output db_state_e state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Inversion is applied on entry so the flops always hold the active-high
  // level; a reset-cleared synchronizer then reads as "released".
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      state <= STABLE_0;
    end else begin
      sync1 <= raw ^ INVERT;
      sync2 <= sync1;
      case (state)
        STABLE_0: begin
          if (!sync2) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= STABLE_1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_1: begin
          if (sync2) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= STABLE_0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE_0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced switch/key input words for the memory-mapped input register.
// Define IO_IN_KEY_LATCH_EN to build key press detection and sticky flags.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int N_SW      = 10,
  parameter int N_KEY     = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  io_input_conditioner_if.slave   io
);

  localparam int FLAG_LSB = flag_base(N_KEY);

  db_state_e        sw_state  [N_SW];
  db_state_e        key_state [N_KEY];
  logic [N_SW-1:0]  sw_db;
  logic [N_KEY-1:0] key_db;
  logic [N_KEY-1:0] flag_next;
  logic [31:0]      port0_next;
  logic [31:0]      port1_next;
  logic [31:0]      port0_q;
  logic [31:0]      port1_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .INVERT    (1'b0)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .raw   (io.sw[i]),
      .state (sw_state[i])
    );
    assign sw_db[i] = (sw_state[i] == STABLE_1);
  end

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .INVERT    (1'b1)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .raw   (io.key_n[i]),
      .state (key_state[i])
    );
    assign key_db[i] = (key_state[i] == STABLE_1);
  end

`ifdef IO_IN_KEY_LATCH_EN
  logic [N_KEY-1:0] key_db_q;
  logic [N_KEY-1:0] key_flag;
  logic [N_KEY-1:0] press;

  // A press in the same cycle as a clear must survive it.
  assign press     = key_db & ~key_db_q;
  assign flag_next = (io.key_clr ? '0 : key_flag) | press;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_db_q <= '0;
      key_flag <= '0;
    end else begin
      key_db_q <= key_db;
      key_flag <= flag_next;
    end
  end
`else
  logic unused_key_clr;
  assign unused_key_clr = io.key_clr;
  assign flag_next      = '0;
`endif

  // Flags go out from flag_next so they appear in the same cycle as the level.
  always_comb begin
    port0_next                         = '0;
    port0_next[N_SW-1:0]               = sw_db;
    port1_next                         = '0;
    port1_next[LEVEL_BASE +: N_KEY]    = key_db;
    port1_next[FLAG_LSB +: N_KEY]      = flag_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      port0_q <= '0;
      port1_q <= '0;
    end else begin
      port0_q <= port0_next;
      port1_q <= port1_next;
    end
  end

  assign io.in_port0 = port0_q;
  assign io.in_port1 = port1_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomized self-checking bench for io_input_conditioner against a
// window-based reference model of the debounce and sticky-flag rules.
module tb_io_input_conditioner;

  localparam int N_SW      = 10;
  localparam int N_KEY     = 4;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 3;
  localparam int NCH       = N_SW + N_KEY;

`ifdef IO_IN_KEY_LATCH_EN
  localparam logic [31:0] EXP_K1_HELD = 32'h22;
  localparam logic [31:0] EXP_K1_REL  = 32'h20;
  localparam logic [31:0] EXP_COINC   = 32'h1;
`else
  localparam logic [31:0] EXP_K1_HELD = 32'h02;
  localparam logic [31:0] EXP_K1_REL  = 32'h00;
  localparam logic [31:0] EXP_COINC   = 32'h0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_input_conditioner_if #(.N_SW(N_SW), .N_KEY(N_KEY)) io_bus ();

  io_input_conditioner #(
    .N_SW      (N_SW),
    .N_KEY     (N_KEY),
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clock (clk),
    .reset (rst),
    .io    (io_bus)
  );

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the synchronized input has disagreed with the
  // debounced value for DB_CYCLES consecutive samples (a sliding window).
  logic [NCH-1:0]   m_p1, m_p2, m_db, m_db_prev;
  logic [N_KEY-1:0] m_flag;
  logic [NCH-1:0]   m_win[$];

  task automatic model_edge();
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   all_diff;
    logic [31:0]      e0;
    logic [31:0]      e1;
`ifdef IO_IN_KEY_LATCH_EN
    logic [N_KEY-1:0] press;
`endif
    raw = {~io_bus.key_n, io_bus.sw};
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_db = '0; m_db_prev = '0; m_flag = '0;
      m_win.delete();
      e0 = '0; e1 = '0;
    end else begin
`ifdef IO_IN_KEY_LATCH_EN
      press  = m_db[NCH-1:N_SW] & ~m_db_prev[NCH-1:N_SW];
      m_flag = (io_bus.key_clr ? '0 : m_flag) | press;
`endif
      e0 = 32'(m_db[N_SW-1:0]);
      e1 = 32'({m_flag, m_db[NCH-1:N_SW]});
      m_db_prev = m_db;
      m_win.push_back(m_p2);
      if (m_win.size() > DB_CYCLES) void'(m_win.pop_front());
      if (m_win.size() == DB_CYCLES) begin
        all_diff = '1;
        foreach (m_win[i]) all_diff &= (m_win[i] ^ m_db);
        m_db ^= all_diff;
      end
      m_p2 = m_p1;
      m_p1 = raw;
    end
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [31:0] e0;
    logic [31:0] e1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    check_eq("in_port0", io_bus.in_port0, e0);
    check_eq("in_port1", io_bus.in_port1, e1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clr();
    io_bus.key_clr = 1'b1;
    tick();
    io_bus.key_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N_SW-1:0]  tmp_sw;
    logic [N_KEY-1:0] tmp_key;
    bit found;

    n_tests = 0;
    n_fail  = 0;
    rst            = 1'b1;
    io_bus.sw      = '0;
    io_bus.key_n   = '1;
    io_bus.key_clr = 1'b0;
    m_p1 = '0; m_p2 = '0; m_db = '0; m_db_prev = '0; m_flag = '0;

    // Outputs hold at zero through reset whatever the pins do.
    for (int i = 0; i < 8; i++) begin
      io_bus.sw    = N_SW'($urandom);
      io_bus.key_n = N_KEY'($urandom);
      tick();
      check_eq("rst_port0", io_bus.in_port0, 32'h0);
      check_eq("rst_port1", io_bus.in_port1, 32'h0);
    end
    io_bus.sw    = '0;
    io_bus.key_n = '1;
    rst          = 1'b0;
    ticks(10);

    // Clean step: visible exactly 7 cycles later.
    io_bus.sw = 10'h2A5;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check_eq("sw_step_lat", io_bus.in_port0, (n < 7) ? 32'h0 : 32'h2A5);
    end
    ticks(3);
    io_bus.sw = '0;
    ticks(10);
    check_eq("sw_step_clr", io_bus.in_port0, 32'h0);

    // Bounce shorter than the debounce window is rejected.
    for (int n = 0; n < 30; n++) begin
      if (n % 3 == 0) io_bus.sw[0] = ~io_bus.sw[0];
      tick();
      check_eq("bounce", io_bus.in_port0, 32'h0);
    end
    io_bus.sw[0] = 1'b0;
    ticks(8);
    check_eq("bounce_end", io_bus.in_port0, 32'h0);

    // Key 1 press, release, then clear.
    io_bus.key_n[1] = 1'b0;
    ticks(10);
    check_eq("key1_held", io_bus.in_port1, EXP_K1_HELD);
    io_bus.key_n[1] = 1'b1;
    ticks(10);
    check_eq("key1_rel", io_bus.in_port1, EXP_K1_REL);
    pulse_clr();
    check_eq("key1_clr", io_bus.in_port1, 32'h0);
    ticks(2);

    // Key 2 press event coinciding with a clear strobe.
    io_bus.key_n[2] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (m_db[N_SW+2] && !m_db_prev[N_SW+2]) begin
        found = 1'b1;
        pulse_clr();
        check_eq("coinc_bit6", 32'(io_bus.in_port1[6]), EXP_COINC);
      end else begin
        tick();
      end
    end
    check_eq("coinc_found", 32'(found), 32'h1);
    io_bus.key_n[2] = 1'b1;
    ticks(10);
    pulse_clr();

    // Key 0 level while held and after release.
    io_bus.key_n[0] = 1'b0;
    ticks(10);
    check_eq("key0_lvl", 32'(io_bus.in_port1[0]), 32'h1);
    io_bus.key_n[0] = 1'b1;
    ticks(10);
    check_eq("key0_rel", 32'(io_bus.in_port1[0]), 32'h0);
    pulse_clr();

    // Reset mid-count, key still held afterwards.
    io_bus.key_n[3] = 1'b0;
    ticks(4);
    rst = 1'b1;
    tick();
    check_eq("midrst_p1", io_bus.in_port1, 32'h0);
    rst = 1'b0;
    ticks(10);
    check_eq("midrst_key3", 32'(io_bus.in_port1[3]), 32'h1);
    io_bus.key_n[3] = 1'b1;
    ticks(10);
    pulse_clr();

    // Random traffic: slow level changes, glitches, clears and resets.
    for (int c = 0; c < 1500; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      io_bus.key_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        tmp_sw = io_bus.sw;
        tmp_sw[$urandom_range(0, N_SW-1)] ^= 1'b1;
        io_bus.sw = tmp_sw;
      end
      if ($urandom_range(0, 4) == 0) begin
        tmp_key = io_bus.key_n;
        tmp_key[$urandom_range(0, N_KEY-1)] ^= 1'b1;
        io_bus.key_n = tmp_key;
      end
      tick();
    end
    rst            = 1'b0;
    io_bus.key_clr = 1'b0;
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
